// File: rtl/afe_daq_pkg.sv
// Shared types and constants for the DAQ word packer.
// Lane word tags, serializer state encoding and the buffered pair layout.
package afe_daq_pkg;

    localparam int WORD_W = 10;
    localparam int N_CH   = 256;
    localparam int CH_W   = $clog2(N_CH);

    localparam logic [1:0] TAG_HDR = 2'b11;
    localparam logic [1:0] TAG_HI  = 2'b10;
    localparam logic [1:0] TAG_LO  = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_HI   = 2'd2,
        S_LO   = 2'd3
    } ser_state_t;

    typedef struct packed {
        logic        first;
        logic [15:0] a;
        logic [15:0] b;
    } pair_t;

    function automatic logic [WORD_W-1:0] mk_word(
        input logic [1:0] tag,
        input logic [7:0] data
    );
        return {tag, data};
    endfunction

endpackage

// File: rtl/sync_fifo_pair.sv
// Pair FIFO: channel pair plus frame-start flag, same-cycle write and read.
// A write while full is ignored even if a read happens in the same cycle.
module sync_fifo_pair
    import afe_daq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  wr,
    input  pair_t wdata,
    input  logic  rd,
    output pair_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    pair_t         mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          do_wr;
    logic          do_rd;

    assign full  = cnt[AW];
    assign empty = (cnt == '0);
    assign rdata = mem[rp];
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= wdata;
    end

endmodule

// File: rtl/daq_word_packer.sv
// Pairs channel-ordered samples and serializes frames onto the DAQ lanes.
// Optional DAQ_TEST_PATTERN_EN adds test_mode, substituting {chan, frame}.
module daq_word_packer
    import afe_daq_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int WORD_CYC   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [15:0]       s_data,
    input  logic [7:0]        s_chan,
`ifdef DAQ_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic [WORD_W-1:0] out_a,
    output logic [WORD_W-1:0] out_b,
    output logic              out_clk,
    output logic              out_sync,
    output logic              seq_err,
    output logic [7:0]        frame_cnt
);

    localparam int PW = $clog2(WORD_CYC);

    logic            rdy_q;
    logic [CH_W-1:0] exp_ch;
    logic            hunt;
    logic [15:0]     hold_a;
    logic [15:0]     sample;
    logic            wr_pend;
    pair_t           wr_data;
    pair_t           head;
    logic            full;
    logic            empty;
    logic            accept;
    logic            in_seq;
    logic            take;

    ser_state_t      st;
    ser_state_t      st_n;
    logic [PW-1:0]   ph;
    logic [PW-1:0]   ph_n;
    logic            adv;
    logic            load;
    logic            pop;
    logic [15:0]     cur_lo;
    logic [WORD_W-1:0] word_a;
    logic [WORD_W-1:0] word_b;
    logic            sync_n;

`ifdef DAQ_TEST_PATTERN_EN
    assign sample = test_mode ? {s_chan, frame_cnt} : s_data;
`else
    assign sample = s_data;
`endif

    assign s_ready = rdy_q && !full;
    assign accept  = s_valid && s_ready;
    assign in_seq  = !hunt && (s_chan == exp_ch);
    // Channel 0 always restarts a frame, whether resyncing or hunting.
    assign take    = in_seq || (s_chan == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdy_q   <= 1'b0;
            exp_ch  <= '0;
            hunt    <= 1'b0;
            seq_err <= 1'b0;
            hold_a  <= '0;
            wr_pend <= 1'b0;
            wr_data <= '0;
        end else begin
            rdy_q   <= 1'b1;
            wr_pend <= 1'b0;
            if (accept) begin
                if (!in_seq) seq_err <= 1'b1;
                if (take) begin
                    hunt   <= 1'b0;
                    exp_ch <= s_chan + 8'd1;
                    if (!s_chan[0]) begin
                        hold_a <= sample;
                    end else begin
                        wr_pend <= 1'b1;
                        wr_data <= '{first: (s_chan == 8'd1),
                                     a: hold_a, b: sample};
                    end
                end else begin
                    hunt <= 1'b1;
                end
            end
        end
    end

    sync_fifo_pair #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .wr    (wr_pend),
        .wdata (wr_data),
        .rd    (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign adv  = (st == S_IDLE) || (ph == PW'(WORD_CYC-1));
    assign load = adv && (st_n != S_IDLE);
    // The pair leaves the FIFO once its high bytes are on the lanes.
    assign pop  = adv && (st == S_HI);
    assign ph_n = adv ? '0 : ph + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) st <= S_IDLE;
        else     st <= st_n;
    end

    always_comb begin
        st_n = st;
        if (adv) begin
            unique case (st)
                S_HDR:   st_n = S_HI;
                S_HI:    st_n = S_LO;
                S_IDLE,
                S_LO:    st_n = empty ? S_IDLE :
                                (head.first ? S_HDR : S_HI);
                default: st_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        word_a = out_a;
        word_b = out_b;
        sync_n = out_sync;
        unique case (st_n)
            S_HDR: begin
                word_a = mk_word(TAG_HDR, frame_cnt);
                word_b = mk_word(TAG_HDR, frame_cnt);
                sync_n = 1'b1;
            end
            S_HI: begin
                word_a = mk_word(TAG_HI, head.a[15:8]);
                word_b = mk_word(TAG_HI, head.b[15:8]);
                sync_n = 1'b0;
            end
            S_LO: begin
                word_a = mk_word(TAG_LO, cur_lo[15:8]);
                word_b = mk_word(TAG_LO, cur_lo[7:0]);
                sync_n = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ph        <= '0;
            out_clk   <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_sync  <= 1'b0;
            frame_cnt <= '0;
            cur_lo    <= '0;
        end else begin
            ph      <= ph_n;
            out_clk <= !adv && (ph_n >= PW'(WORD_CYC/2));
            if (load) begin
                out_a    <= word_a;
                out_b    <= word_b;
                out_sync <= sync_n;
            end
            if (load && st_n == S_HI) cur_lo <= {head.a[7:0], head.b[7:0]};
            if (adv && st == S_HDR) frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule
